lit_writer: RTL
===============

LIT_WRITER -- requirements
Module: lit_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 85, giving the literal-token width.
REQ-002 SHALL have parameter ADDR_W, default 16, giving the history-buffer byte-address width.
REQ-003 SHALL have port clk  input  1  as its single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  as its reset: asynchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  as the literal-FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  WIDTH  as the literal-FIFO read data, valid on the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  as the literal-FIFO pop strobe.
REQ-008 SHALL have port ram_wr_en  output  1  as the history-RAM write request.
REQ-009 SHALL have port ram_ready  input  1  as the RAM accept signal; a beat is accepted on a cycle where ram_wr_en=1 and ram_ready=1.
REQ-010 SHALL have port ram_wr_addr  output  ADDR_W-3  as the 8-byte word address.
REQ-011 SHALL have port ram_wr_data  output  64  as the write data, byte k on bits [8k+7:8k].
REQ-012 SHALL have port ram_wr_be  output  8  as the per-byte write enables.
REQ-013 SHALL have port busy  output  1, high whenever the FSM is not IDLE.
REQ-014 SHALL have port last_done  output  1, a one-cycle pulse when the final beat of a token with last=1 is accepted.
REQ-015 SHALL have port err  output  1, a sticky illegal-count flag.

Function
REQ-016 SHALL decode the token as: [84] last, [83:80] cnt (bytes, legal 1..8), [79:64] byte address A, [63:0] data (byte 0 at [7:0], lowest address).
REQ-017 SHALL use an FSM with states IDLE, FETCH, LO and HI.
REQ-018 SHALL, in IDLE with fifo_empty=0, assert fifo_rd_en for exactly one cycle and move to FETCH.
REQ-019 SHALL keep fifo_rd_en low in every state other than IDLE, so at most one pop is outstanding.
REQ-020 SHALL, in FETCH, register fifo_dout into a token register and move to LO.
REQ-021 SHALL, in FETCH with cnt=0 or cnt>8, discard the token, set err, issue no write and return to IDLE.
REQ-022 SHALL form, with off=A[2:0], a 16-bit enable mask be16 = ((1<<cnt)-1)<<off and a 128-bit word d128 = (data with bytes >=cnt zeroed) << 8*off.
REQ-023 SHALL, in LO, drive ram_wr_en=1, ram_wr_addr=A[ADDR_W-1:3], ram_wr_be=be16[7:0] and ram_wr_data=d128[63:0].
REQ-024 SHALL hold all LO outputs stable until accepted.
REQ-025 SHALL, on LO acceptance, go to HI if be16[15:8]!=0, else go to IDLE.
REQ-026 SHALL, in HI, drive ram_wr_en=1, ram_wr_addr=A[ADDR_W-1:3]+1 modulo 2^(ADDR_W-3), ram_wr_be=be16[15:8] and ram_wr_data=d128[127:64], held until accepted.
REQ-027 SHALL, on HI acceptance, return to IDLE.
REQ-028 SHALL drive ram_wr_en, ram_wr_addr, ram_wr_data and ram_wr_be directly from registers; ram_wr_en=0 in IDLE and FETCH.
REQ-029 SHALL assert last_done on the cycle after the final beat of a last=1 token is accepted.
REQ-030 SHALL have a minimum spacing of 3 cycles per single-beat token and 4 cycles per two-beat token with ram_ready held high.
REQ-031 SHALL keep err set until reset; err SHALL NOT stall processing of later tokens.

Reset
REQ-032 SHALL, while rst_n=0, force FSM=IDLE, fifo_rd_en=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_wr_be=0, busy=0, last_done=0 and err=0, regardless of the clock.
REQ-033 SHALL, on reset assertion mid-token (FETCH/LO/HI), abandon the token with no further writes; the upstream FIFO is reset by the same event.
REQ-034 SHALL allow the first pop no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-035 Aligned write: token cnt=8, A=0x0010, data=0x0706050403020100, last=0 -> one beat with addr=0x002, be=0xFF, data unchanged; no last_done.
REQ-036 Crossing write: cnt=5, A=0x0006, data=0x..4443424140 -> LO addr=0x000, be=0xC0, data[63:48]=0x4140; HI addr=0x001, be=0x07, data[23:0]=0x444342.
REQ-037 Backpressure: ram_ready=0 for 4 cycles during LO -> ram_wr_* held constant for those cycles; single accept; no extra fifo_rd_en.
REQ-038 Wrap and last: cnt=4, A=0xFFFE, last=1 -> LO addr=0x1FFF, be=0xC0; HI addr=0x0000, be=0x03; last_done pulses for 1 cycle.
REQ-039 Illegal count: cnt=0, then cnt=9, then a legal token -> no writes for the first two, err=1 and stays 1, third token written normally.
REQ-040 Reset mid-operation: rst_n low during HI with ram_ready=0 -> all outputs 0 immediately; after release, fifo_empty=1 keeps fifo_rd_en at 0.

Source files
------------

// File: rtl/lit_writer.sv
// Literal writer: pops one literal token at a time and writes its 1..8 bytes
// into the 64-bit history RAM as one beat, or two beats when it crosses a word.
module lit_writer #(
  parameter int WIDTH  = 85,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_dout,
  output logic              fifo_rd_en,
  output logic              ram_wr_en,
  input  logic              ram_ready,
  output logic [ADDR_W-4:0] ram_wr_addr,
  output logic [63:0]       ram_wr_data,
  output logic [7:0]        ram_wr_be,
  output logic              busy,
  output logic              last_done,
  output logic              err
);

  typedef struct packed {
    logic        last;
    logic [3:0]  cnt;
    logic [15:0] addr;
    logic [63:0] data;
  } tok_t;

  typedef enum logic [1:0] {IDLE, FETCH, LO, HI} state_t;

  localparam logic [ADDR_W-4:0] WORD_ONE = {{(ADDR_W-4){1'b0}}, 1'b1};

  function automatic logic [15:0] mk_be(tok_t t);
    return ((16'h1 << t.cnt) - 16'h1) << t.addr[2:0];
  endfunction

  // Bytes at or above cnt are zeroed before shifting into the 128-bit window.
  function automatic logic [127:0] mk_data(tok_t t);
    logic [127:0] m;
    m = (128'h1 << {t.cnt, 3'b000}) - 128'h1;
    return ({64'h0, t.data} & m) << {t.addr[2:0], 3'b000};
  endfunction

  state_t       state, nxt;
  tok_t         tok, tok_in;
  logic         rdy_q;
  logic         legal_in, accept;
  logic [15:0]  be_in, be_t;
  logic [127:0] d_in, d_t;

  assign tok_in   = tok_t'(fifo_dout[84:0]);
  assign legal_in = (tok_in.cnt != 4'd0) && (tok_in.cnt <= 4'd8);
  assign accept   = ram_wr_en & ram_ready;
  assign be_in    = mk_be(tok_in);
  assign d_in     = mk_data(tok_in);
  assign be_t     = mk_be(tok);
  assign d_t      = mk_data(tok);

  // rdy_q holds off the first pop until the first edge after reset release.
  assign fifo_rd_en = (state == IDLE) && rdy_q && !fifo_empty;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= nxt;
      rdy_q <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (rdy_q && !fifo_empty) nxt = FETCH;
      FETCH: nxt = legal_in ? LO : IDLE;
      LO:    if (accept) nxt = (be_t[15:8] != 8'h0) ? HI : IDLE;
      HI:    if (accept) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok         <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_wr_be   <= '0;
      last_done   <= 1'b0;
      err         <= 1'b0;
    end else begin
      last_done <= 1'b0;
      case (state)
        FETCH: begin
          tok <= tok_in;
          if (legal_in) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= tok_in.addr[ADDR_W-1:3];
            ram_wr_be   <= be_in[7:0];
            ram_wr_data <= d_in[63:0];
          end else begin
            err <= 1'b1;
          end
        end
        LO: if (accept) begin
          if (be_t[15:8] != 8'h0) begin
            ram_wr_addr <= tok.addr[ADDR_W-1:3] + WORD_ONE;
            ram_wr_be   <= be_t[15:8];
            ram_wr_data <= d_t[127:64];
          end else begin
            ram_wr_en <= 1'b0;
            last_done <= tok.last;
          end
        end
        HI: if (accept) begin
          ram_wr_en <= 1'b0;
          last_done <= tok.last;
        end
        default: ;
      endcase
    end
  end

endmodule
